muldiv_hilo_unit: RTL and testbench
===================================

# muldiv_hilo_unit

Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers. It replaces the combinational multiplier, the stand-alone divider and the two HILO registers in the EX/WB path. It executes signed and unsigned MULT and DIV, the accumulate forms MADD and MSUB, and the direct writes MTHI and MTLO. A start/busy/done handshake drives the hazard unit's EX stall, and a cancel input lets an exception or branch flush abort an operation in flight.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; WIDTH ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- start  in  1  launch request, sampled only when busy=0.
- op  in  4  operation code from muldiv_pkg, sampled together with start.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- cancel  in  1  aborts the current operation; HI/LO are left unchanged.
- busy  out  1  operation in flight; the hazard unit stalls EX on it.
- done  out  1  one-cycle pulse in the cycle HI/LO are written by MULT/DIV/MADD/MSUB.
- hi  out  WIDTH  HI register contents.
- lo  out  WIDTH  LO register contents.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start with MTHI: hi←a at the next edge; no busy, no done.
  - start with MTLO: lo←a at the next edge; no busy, no done.
  - start with any other valid op: latch op, |a|, |b|, sign flags and count=0, then go to CALC.
  - Undefined op codes: ignored.
- CALC:
  - Multiply ops use radix-2 shift-add: WIDTH iterations, one per cycle, 2·WIDTH-bit product on magnitudes.
  - Divide ops use radix-2 restoring shift-subtract: WIDTH iterations, one per cycle.
  - After iteration WIDTH, go to FIX.
- FIX (one cycle, done=1):
  - Sign correction:
    - Signed ops: product negated if sign(a)≠sign(b).
    - Signed division: quotient negated if sign(a)≠sign(b); remainder takes the sign of a.
  - Write-back:
    - MULT/MULTU: {hi,lo}←product.
    - DIV/DIVU: lo←quotient, hi←remainder.
    - MADD/MADDU: {hi,lo}←{hi,lo}+product, modulo 2^(2·WIDTH).
    - MSUB/MSUBU: {hi,lo}←{hi,lo}−product, modulo 2^(2·WIDTH).
  - Return to IDLE.
- Divide by zero (b=0), signed or unsigned: lo←all ones, hi←a. Latency is unchanged.
- Signed MIN/−1: lo←MIN, hi←0. This falls out of magnitude arithmetic and needs no special case.
- cancel:
  - In CALC or FIX, go to IDLE at the next edge, with no done and no HI/LO write.
  - cancel has priority over FIX write-back.
  - cancel in IDLE has no effect. This includes cancel together with start: cancel wins and nothing is launched, MTHI/MTLO included.
- start while busy=1: ignored. The hazard unit guarantees it holds the instruction.

## Timing
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter and operand latches 0.
- Reset mid-operation: everything returns to reset values immediately; the result is discarded.
- start accepted at edge E0. busy=1 in cycles E0+1 … E0+WIDTH+1. done=1 in cycle E0+WIDTH+1 (FIX). New hi/lo are visible from E0+WIDTH+2.
- Total latency is WIDTH+2 edges. For WIDTH=32, done occurs 33 cycles after the start edge.
- busy is high combinationally in the FIX cycle and drops in the cycle after. A new start can therefore be accepted at the edge ending the cycle in which busy first reads 0.
- MTHI/MTLO: one-edge write; the value is visible in the next cycle.
- The accumulate forms read hi/lo in the FIX cycle. Those are equal to the values at start because no writes are accepted while busy.
- hi/lo are register outputs with no combinational bypass. The hazard unit forwards from done if needed.

## Structure
- muldiv_pkg holds:
  - op codes (4-bit): OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MADD=4, OP_MADDU=5, OP_MSUB=6, OP_MSUBU=7, OP_MTHI=8, OP_MTLO=9;
  - state encoding: IDLE=0, CALC=1, FIX=2;
  - helpers is_signed(op), is_div(op), is_acc(op), is_sub(op).
- Sub-module mdu_iter_core(WIDTH): the shared shift register and WIDTH+1-bit adder/subtractor performing one multiply or divide iteration per cycle under an is_div select.
- The top level holds the FSM, counter, sign handling, accumulate adder and HI/LO registers.

## Test plan
All scenarios use WIDTH=32.
- MULT a=0xFFFFFFFD (−3), b=7 → after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly one cycle; busy high 33 cycles.
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5 at normal latency. DIVU a=0xFFFFFFF0, b=0 → lo=0xFFFFFFFF, hi=0xFFFFFFF0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1·1 → hi=1, lo=0. Then MSUB 2·3 → hi=0, lo=0xFFFFFFFA.
- DIV started, cancel asserted 10 cycles later → done never pulses, hi/lo unchanged, busy=0 next cycle. A start asserted in the cycle after cancel (while busy=0) → the new op is accepted at that cycle's closing edge and completes normally. A start asserted while busy=1 → ignored.
- rst asserted asynchronously mid-CALC → busy=0, hi=lo=0 immediately. No done pulse after rst is released.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op-class helpers for the multiply/divide unit
package muldiv_pkg;
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} mduState;
  function automatic logic is_signed(input logic [3:0] op);
    return !op[0] && !op[3];
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op[3:1] == 3'b001;
  endfunction
  function automatic logic is_acc(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction
  function automatic logic is_sub(input logic [3:0] op);
    return op[3:1] == 3'b011;
  endfunction
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: shared 2*WIDTH shift register and WIDTH+1-bit adder doing one
// shift-add multiply or restoring shift-subtract divide step per enabled cycle
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic               isDiv,
  input  logic [WIDTH-1:0]   initLo,
  input  logic [WIDTH-1:0]   initM,
  output logic [2*WIDTH-1:0] prod
);
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] addA, addB, sum;
  // divide subtracts m via inverted operand plus carry-in; sum[WIDTH] is the borrow
  always_comb begin
    addA = isDiv ? prod[2*WIDTH-1:WIDTH-1] : {1'b0, prod[2*WIDTH-1:WIDTH]};
    addB = isDiv ? ~{1'b0, m} : {1'b0, m & {WIDTH{prod[0]}}};
    sum = addA + addB + {{WIDTH{1'b0}}, isDiv};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prod <= '0;
      m <= '0;
    end else if (load) begin
      prod <= {{WIDTH{1'b0}}, initLo};
      m <= initM;
    end else if (en)
      prod <= isDiv ? (sum[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                                  : {sum[WIDTH-1:0], prod[WIDTH-2:0], 1'b1})
                    : {sum, prod[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle signed/unsigned MULT/DIV/MADD/MSUB with HI/LO
// registers, MTHI/MTLO writes and a start/busy/done/cancel handshake
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mduState state, nextState;
  logic [3:0] opReg;
  logic [CNT_W-1:0] count;
  logic negRes, negRem, divZero, launch, accept;
  logic [WIDTH-1:0] aMag, bMag, quo, rem;
  logic [2*WIDTH-1:0] prod, prodS, hiLoNext;
  mdu_iter_core #(.WIDTH(WIDTH)) core (
    .clk(clk), .rst(rst), .load(launch), .en(state == CALC), .isDiv(is_div(opReg)),
    .initLo(is_div(op) ? aMag : bMag), .initM(is_div(op) ? bMag : aMag), .prod(prod)
  );
  always_comb begin
    aMag = is_signed(op) && a[WIDTH-1] ? -a : a;
    bMag = is_signed(op) && b[WIDTH-1] ? -b : b;
    accept = state == IDLE && start && !cancel;
    launch = accept && op < OP_MTHI;
    busy = state != IDLE;
    done = state == FIX && !cancel;
    nextState = state;
    if (cancel && state != IDLE) nextState = IDLE;
    else if (launch) nextState = CALC;
    else if (state == CALC && count == CNT_W'(WIDTH - 1)) nextState = FIX;
    else if (state == FIX) nextState = IDLE;
    // divide-by-zero quotient is forced so the sign fix cannot disturb it
    quo = divZero ? '1 : negRes ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem = negRem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    prodS = negRes ? -prod : prod;
    hiLoNext = is_div(opReg) ? {rem, quo} : !is_acc(opReg) ? prodS :
               is_sub(opReg) ? {hi, lo} - prodS : {hi, lo} + prodS;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      opReg <= '0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      divZero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= nextState;
      count <= state == CALC ? count + CNT_W'(1) : '0;
      if (launch) begin
        opReg <= op;
        negRes <= is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
        negRem <= is_signed(op) && a[WIDTH-1];
        divZero <= b == '0;
      end
      if (done) {hi, lo} <= hiLoNext;
      else if (accept && op == OP_MTHI) hi <= a;
      else if (accept && op == OP_MTLO) lo <= a;
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed-vector bench for muldiv_hilo_unit at WIDTH=32
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;
  logic clk = 0, rst = 0, start = 0, cancel = 0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  int busyN, doneN, doneAt;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1;
    tick();
    start = 0;
  endtask

  task automatic waitDone(input int n);
    busyN = 0; doneN = 0; doneAt = -1;
    for (int i = 0; i < n; i++) begin
      if (busy) busyN++;
      if (done) begin doneN++; doneAt = i; end
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    issue(o, x, y);
    waitDone(40);
    chk({tag, "_busy"}, busyN, 33);
    chk({tag, "_done"}, doneN, 1);
    chk({tag, "_doneAt"}, doneAt, 32);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1;
    tick();
    runOp("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    runOp("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    runOp("div_z", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    runOp("divu_z", OP_DIVU, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    runOp("multu", OP_MULTU, 32'h10000, 32'h30000, 32'd3, 32'd0);
    issue(OP_MTHI, 32'd0, 32'd0);
    chk("mthi_hi", hi, 0);
    chk("mthi_busy", busy, 0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0);
    chk("mtlo_lo", lo, 32'hFFFFFFFF);
    chk("mtlo_done", done, 0);
    runOp("maddu", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0);
    runOp("msub", OP_MSUB, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA);
    cancel = 1;
    issue(OP_MTHI, 32'h55, 32'd0);
    chk("idlecan_hi", hi, 0);
    issue(OP_DIV, 32'd9, 32'd2);
    cancel = 0;
    chk("idlecan_busy", busy, 0);
    issue(OP_DIV, 32'd100, 32'd3);
    waitDone(10);
    cancel = 1;
    if (done) doneN++;
    tick();
    cancel = 0;
    chk("cancel_done", doneN, 0);
    chk("cancel_busy", busy, 0);
    chk("cancel_hi", hi, 0);
    chk("cancel_lo", lo, 32'hFFFFFFFA);
    runOp("aftercan", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (5) tick();
    op = OP_MTLO; a = 32'hBAD; start = 1;
    tick();
    start = 0;
    waitDone(40);
    chk("busystart_done", doneN, 1);
    chk("busystart_hi", hi, 0);
    chk("busystart_lo", lo, 30);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) tick();
    #2 rst = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    #3 rst = 1;
    tick();
    waitDone(40);
    chk("postrst_done", doneN, 0);
    chk("postrst_busy", busyN, 0);
    chk("postrst_lo", lo, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
